// File: rtl/picosoc_debug_master_if.sv
// iomem initiator bus plus arbiter request/grant, as seen by the debug bridge.
interface picosoc_debug_master_if;
  logic        bus_req;
  logic        bus_gnt;
  logic        iomem_valid;
  logic        iomem_instr;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        iomem_ready;

  modport master (
    output bus_req, iomem_valid, iomem_instr, iomem_wstrb, iomem_addr, iomem_wdata,
    input  bus_gnt, iomem_rdata, iomem_ready
  );

  modport slave (
    input  bus_req, iomem_valid, iomem_instr, iomem_wstrb, iomem_addr, iomem_wdata,
    output bus_gnt, iomem_rdata, iomem_ready
  );
endinterface

// File: rtl/picosoc_debug_master.sv
// Byte-stream debug bridge: decodes 'W'/'R' frames from the UART receiver into
// single iomem transactions and streams the status or read data back out.
//
// state  | meaning
// IDLE   | waiting for a command byte
// ADDR   | collecting 4 address bytes, LSB first
// DATA   | collecting 4 write-data bytes, LSB first
// REQ    | bus_req high, waiting for the arbiter grant
// BUS    | iomem_valid held until ready or timeout
// RESP   | sending the response byte(s)
module picosoc_debug_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RX_IDLE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  picosoc_debug_master_if.master bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int IW = (RX_IDLE_CYCLES > 1) ? $clog2(RX_IDLE_CYCLES) : 1;

  localparam logic [7:0] CMD_W  = 8'h57;
  localparam logic [7:0] CMD_R  = 8'h52;
  localparam logic [7:0] RSP_OK = 8'h4B;
  localparam logic [7:0] RSP_TO = 8'h54;
  localparam logic [7:0] RSP_BAD = 8'h3F;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_REQ, S_BUS, S_RESP} state_t;

  state_t      state, state_n;
  logic        op_write, op_write_n;
  logic [1:0]  cnt, cnt_n;
  logic [31:0] addr, addr_n;
  logic [31:0] wdata, wdata_n;
  logic [IW-1:0] idle_cnt, idle_cnt_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic [23:0] resp_sh, resp_sh_n;
  logic [1:0]  resp_left, resp_left_n;
  logic [7:0]  tx_data_n;
  logic        tx_valid_n;
  logic        bus_req, bus_req_n;
  logic        mem_valid, mem_valid_n;
  logic [3:0]  wstrb, wstrb_n;
  logic        busy_n;

  assign bus.bus_req     = bus_req;
  assign bus.iomem_valid = mem_valid;
  assign bus.iomem_instr = 1'b0;
  assign bus.iomem_wstrb = wstrb;
  assign bus.iomem_addr  = addr;
  assign bus.iomem_wdata = wdata;

  always_comb begin
    state_n     = state;
    op_write_n  = op_write;
    cnt_n       = cnt;
    addr_n      = addr;
    wdata_n     = wdata;
    idle_cnt_n  = idle_cnt;
    to_cnt_n    = to_cnt;
    resp_sh_n   = resp_sh;
    resp_left_n = resp_left;
    tx_data_n   = tx_data;
    tx_valid_n  = tx_valid;
    bus_req_n   = bus_req;
    mem_valid_n = mem_valid;
    wstrb_n     = wstrb;

    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_W || rx_data == CMD_R) begin
            op_write_n = (rx_data == CMD_W);
            cnt_n      = 2'd0;
            idle_cnt_n = '0;
            state_n    = S_ADDR;
          end else begin
            tx_data_n   = RSP_BAD;
            tx_valid_n  = 1'b1;
            resp_left_n = 2'd0;
            state_n     = S_RESP;
          end
        end
      end

      S_ADDR, S_DATA: begin
        if (rx_valid) begin
          if (state == S_ADDR) addr_n[8*cnt +: 8] = rx_data;
          else                 wdata_n[8*cnt +: 8] = rx_data;
          cnt_n      = cnt + 2'd1;
          idle_cnt_n = '0;
          if (cnt == 2'd3) begin
            if (state == S_ADDR && op_write) begin
              state_n = S_DATA;
            end else begin
              bus_req_n = 1'b1;
              state_n   = S_REQ;
            end
          end
        end else if (idle_cnt == IW'(RX_IDLE_CYCLES - 1)) begin
          // Host went quiet mid-frame: drop it and wait for a fresh command.
          state_n = S_IDLE;
        end else begin
          idle_cnt_n = idle_cnt + IW'(1);
        end
      end

      S_REQ: begin
        if (bus.bus_gnt) begin
          mem_valid_n = 1'b1;
          wstrb_n     = op_write ? 4'hF : 4'h0;
          to_cnt_n    = '0;
          state_n     = S_BUS;
        end
      end

      S_BUS: begin
        // Ready takes priority over an expiring timeout in the same cycle.
        if (bus.iomem_ready) begin
          mem_valid_n = 1'b0;
          bus_req_n   = 1'b0;
          tx_valid_n  = 1'b1;
          state_n     = S_RESP;
          if (op_write) begin
            tx_data_n   = RSP_OK;
            resp_left_n = 2'd0;
          end else begin
            tx_data_n   = bus.iomem_rdata[7:0];
            resp_sh_n   = bus.iomem_rdata[31:8];
            resp_left_n = 2'd3;
          end
        end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          mem_valid_n = 1'b0;
          bus_req_n   = 1'b0;
          tx_data_n   = RSP_TO;
          tx_valid_n  = 1'b1;
          resp_left_n = 2'd0;
          state_n     = S_RESP;
        end else begin
          to_cnt_n = to_cnt + TW'(1);
        end
      end

      S_RESP: begin
        if (tx_ready) begin
          if (resp_left == 2'd0) begin
            tx_valid_n = 1'b0;
            state_n    = S_IDLE;
          end else begin
            tx_data_n   = resp_sh[7:0];
            resp_sh_n   = {8'h00, resp_sh[23:8]};
            resp_left_n = resp_left - 2'd1;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      op_write  <= 1'b0;
      cnt       <= 2'd0;
      addr      <= '0;
      wdata     <= '0;
      idle_cnt  <= '0;
      to_cnt    <= '0;
      resp_sh   <= '0;
      resp_left <= 2'd0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      bus_req   <= 1'b0;
      mem_valid <= 1'b0;
      wstrb     <= 4'h0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      op_write  <= op_write_n;
      cnt       <= cnt_n;
      addr      <= addr_n;
      wdata     <= wdata_n;
      idle_cnt  <= idle_cnt_n;
      to_cnt    <= to_cnt_n;
      resp_sh   <= resp_sh_n;
      resp_left <= resp_left_n;
      tx_data   <= tx_data_n;
      tx_valid  <= tx_valid_n;
      bus_req   <= bus_req_n;
      mem_valid <= mem_valid_n;
      wstrb     <= wstrb_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_picosoc_debug_master.sv
// Directed bench for the debug bridge: table of frames with expected bus and
// response behaviour, plus hand sequences for resync, grant wait and reset abort.
module tb_picosoc_debug_master;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  picosoc_debug_master_if bus_if();

  picosoc_debug_master #(.TIMEOUT_CYCLES(16), .RX_IDLE_CYCLES(100)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Slave model state; only the monitor process writes these.
  int          ready_at = 0;
  int          txn = 0, vcyc = 0, vc_cur = 0, unstable = 0, breq = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;

  always @(negedge clk) begin
    if (bus_if.iomem_valid) begin
      if (!prev_valid) begin
        txn++;
        cap_addr  = bus_if.iomem_addr;
        cap_wdata = bus_if.iomem_wdata;
        cap_wstrb = bus_if.iomem_wstrb;
      end else if (bus_if.iomem_addr !== cap_addr || bus_if.iomem_wdata !== cap_wdata ||
                   bus_if.iomem_wstrb !== cap_wstrb) begin
        unstable++;
      end
      vcyc++;
      vc_cur++;
      bus_if.iomem_ready = (vc_cur == ready_at);
    end else begin
      vc_cur = 0;
      bus_if.iomem_ready = 1'b0;
    end
    prev_valid = bus_if.iomem_valid;
    if (bus_if.bus_req) breq++;
  end

  typedef struct {
    logic [71:0] frame;
    int          nfr;
    logic [31:0] rdata;
    int          rdy;
    int          stall;
    int          exp_txn;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    int          exp_vcyc;
    logic [31:0] exp_resp;
    int          nresp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [71:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_data  = f[8*i +: 8];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int t0, b0, u0, vc0, n, sc, budget, txu;
    logic [31:0] resp;
    logic [7:0]  prev;
    t0 = txn; b0 = breq; u0 = unstable; vc0 = vcyc;
    n = 0; sc = 0; budget = 0; txu = 0; resp = '0; prev = 8'h00;
    ready_at = v.rdy;
    bus_if.iomem_rdata = v.rdata;
    send_frame(v.frame, v.nfr);
    if (v.exp_txn != 0) begin
      chk({name, " bus_req at +1"}, 32'(bus_if.bus_req), 32'd1);
      chk({name, " valid not before +2"}, 32'(bus_if.iomem_valid), 32'd0);
    end
    while (budget < 300) begin
      @(negedge clk);
      budget++;
      if (tx_valid) begin
        if (sc > 0 && tx_data !== prev) txu++;
        prev = tx_data;
        if (sc < v.stall) begin
          tx_ready = 1'b0;
          sc++;
        end else begin
          tx_ready = 1'b1;
          if (n < 4) resp[8*n +: 8] = tx_data;
          n++;
          sc = 0;
        end
      end else begin
        tx_ready = 1'b0;
        if (!busy) break;
      end
    end
    tx_ready = 1'b0;
    chk({name, " back to idle"}, 32'(busy), 32'd0);
    chk({name, " resp byte count"}, 32'(n), 32'(v.nresp));
    chk({name, " resp bytes"}, resp, v.exp_resp);
    chk({name, " tx_data held while stalled"}, 32'(txu), 32'd0);
    chk({name, " transactions"}, 32'(txn - t0), 32'(v.exp_txn));
    if (v.exp_txn != 0) begin
      chk({name, " addr"}, cap_addr, v.exp_addr);
      chk({name, " wstrb"}, 32'(cap_wstrb), 32'(v.exp_wstrb));
      if (v.exp_wstrb == 4'hF) chk({name, " wdata"}, cap_wdata, v.exp_wdata);
      chk({name, " valid cycles"}, 32'(vcyc - vc0), 32'(v.exp_vcyc));
      chk({name, " bus stable"}, 32'(unstable - u0), 32'd0);
    end else begin
      chk({name, " no bus_req"}, 32'(breq - b0), 32'd0);
    end
  endtask

  vec_t vecs[6];
  vec_t rv;
  int   b0, t0;

  initial begin
    vecs[0] = '{72'hDEADBEEF_00000010_57, 9, 32'h0, 2, 0, 1, 32'h00000010, 32'hDEADBEEF, 4'hF, 2, 32'h4B, 1};
    vecs[1] = '{72'h04000000_52, 5, 32'h12345678, 5, 3, 1, 32'h04000000, 32'h0, 4'h0, 5, 32'h12345678, 4};
    vecs[2] = '{72'h11223344_52, 5, 32'hCAFEF00D, 0, 0, 1, 32'h11223344, 32'h0, 4'h0, 16, 32'h54, 1};
    vecs[3] = '{72'h04030201_00000100_57, 9, 32'h0, 16, 1, 1, 32'h00000100, 32'h04030201, 4'hF, 16, 32'h4B, 1};
    vecs[4] = '{72'h41, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h3F, 1};
    vecs[5] = '{72'h00000008_52, 5, 32'hA5A55A5A, 1, 1, 1, 32'h00000008, 32'h0, 4'h0, 1, 32'hA5A55A5A, 4};

    resetn = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    bus_if.bus_gnt = 1'b1;
    bus_if.iomem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset tx_valid", 32'(tx_valid), 32'd0);
    chk("reset tx_data", 32'(tx_data), 32'd0);
    chk("reset bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("reset iomem_valid", 32'(bus_if.iomem_valid), 32'd0);
    chk("reset wstrb", 32'(bus_if.iomem_wstrb), 32'd0);
    chk("reset addr", bus_if.iomem_addr, 32'd0);
    chk("reset wdata", bus_if.iomem_wdata, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("instr tied low", 32'(bus_if.iomem_instr), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Partial write frame then silence: resync exactly after the idle limit.
    b0 = breq;
    send_frame(72'h0201_57, 3);
    repeat (99) @(negedge clk);
    chk("resync busy before limit", 32'(busy), 32'd1);
    @(negedge clk);
    chk("resync busy after limit", 32'(busy), 32'd0);
    chk("resync no bus_req", 32'(breq - b0), 32'd0);
    rv = '{72'h12345678_52, 5, 32'h89ABCDEF, 3, 0, 1, 32'h12345678, 32'h0, 4'h0, 3, 32'h89ABCDEF, 4};
    run_vec(rv, "after resync");

    // Grant withheld, then reset while valid is high.
    bus_if.bus_gnt = 1'b0;
    ready_at = 0;
    t0 = txn;
    send_frame(72'h00000020_52, 5);
    repeat (10) @(negedge clk);
    chk("gnt wait bus_req", 32'(bus_if.bus_req), 32'd1);
    chk("gnt wait no valid", 32'(bus_if.iomem_valid), 32'd0);
    bus_if.bus_gnt = 1'b1;
    repeat (3) @(negedge clk);
    chk("granted valid", 32'(bus_if.iomem_valid), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort valid", 32'(bus_if.iomem_valid), 32'd0);
    chk("abort bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("abort tx_valid", 32'(tx_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort no response", 32'(tx_valid), 32'd0);
    chk("abort single transaction", 32'(txn - t0), 32'd1);
    rv = '{72'h00000077_00000040_57, 9, 32'h0, 2, 2, 1, 32'h00000040, 32'h00000077, 4'hF, 2, 32'h4B, 1};
    run_vec(rv, "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/picosoc_debug_master.md
Name: picosoc_debug_master

Overview:
- Second bus initiator on the PicoSoC iomem bus: a byte-stream debug bridge.
- Takes framed read/write commands from an external UART receiver byte stream and issues single 32-bit iomem transactions.
- Drives the same valid/ready protocol the picorv32 core drives; an external arbiter muxes it against the CPU.
- Returns read data or a status byte on a transmit byte stream, for host-side peek/poke of SRAM, SDRAM and A2FPGA registers without firmware.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles iomem_valid is held without iomem_ready before abort.
- RX_IDLE_CYCLES, 500000: max gap between bytes of one frame before silent resync to IDLE.

Ports:
- clk  in  1  system clock (clk_logic domain)
- resetn  in  1  synchronous reset, active-low
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  transmitter accepts on tx_valid && tx_ready
- bus_req  out  1  request iomem ownership from arbiter
- bus_gnt  in  1  arbiter grant; bridge owns bus while high
- iomem_valid  out  1  transaction request
- iomem_instr  out  1  constant 0
- iomem_wstrb  out  4  4'hF write, 4'h0 read
- iomem_addr  out  32  byte address
- iomem_wdata  out  32  write data
- iomem_rdata  in  32  read data, valid when iomem_ready
- iomem_ready  in  1  transaction complete
- busy  out  1  high in any state except IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (resetn).
- Reset values: tx_valid=0, tx_data=0, bus_req=0, iomem_valid=0, iomem_wstrb=0, iomem_addr=0, iomem_wdata=0, busy=0, state=IDLE.
- A resetn low mid-operation aborts immediately at that edge; no response byte is sent.
- Frame format: multi-byte fields little-endian.
  - Write: 0x57 'W', addr b0..b3, data b0..b3.
  - Read: 0x52 'R', addr b0..b3.
- States: IDLE, ADDR, DATA, REQ, BUS, RESP.
- IDLE, on rx_valid:
  - 0x57 or 0x52: latch op, go to ADDR, clear byte counter.
  - Any other byte: load tx_data=0x3F '?', go to RESP.
- ADDR: 4 bytes shift into addr[8*n+:8] (2-bit counter). After 4th byte: write goes to DATA; read goes to REQ.
- DATA: 4 bytes into wdata the same way, then REQ.
- Inter-byte gap in ADDR/DATA: an idle counter resets on each rx_valid. At RX_IDLE_CYCLES it returns to IDLE silently and discards the partial frame.
- REQ: bus_req=1; waits unbounded for bus_gnt. On the first cycle bus_gnt=1, next cycle enters BUS with iomem_valid=1.
- BUS, per picorv32 rules:
  - addr/wdata/wstrb stable while iomem_valid=1.
  - Completion is the cycle with iomem_valid && iomem_ready. iomem_rdata is captured that cycle.
  - iomem_valid and bus_req deassert at the next edge.
  - Timeout counter starts at 0 on entry and increments each cycle without ready.
  - Counter reaching TIMEOUT_CYCLES-1 with no ready: drop valid/bus_req at the next edge, response 0x54 'T'.
  - Ready in the same cycle as timeout expiry: ready wins (normal completion).
  - bus_gnt dropping during BUS is an arbiter error; the bridge ignores it and keeps valid held.
- Responses, sent from RESP:
  - Write OK: 0x4B 'K'.
  - Read OK: 4 bytes, rdata b0 first.
  - Timeout: 'T'.
  - Bad command: '?'.
- RESP handshake:
  - tx_valid=1 with tx_data stable until tx_valid && tx_ready.
  - Next byte is presented on the following cycle, with tx_valid staying high.
  - After the last byte, tx_valid=0 and state=IDLE the next cycle.
- rx bytes arriving in REQ/BUS/RESP are dropped, not queued.
- busy=1 in all states except IDLE, registered with the state.
- Latency: last frame byte → bus_req at +1 cycle. With bus_gnt already high, iomem_valid follows at +2 cycles.

Test Plan:
- Write: rx 57 10 00 00 00 EF BE AD DE, gnt tied 1, ready on 2nd valid cycle → one transaction with addr=0x00000010, wdata=0xDEADBEEF, wstrb=F, valid high exactly 2 cycles, then tx 0x4B.
- Read: rx 52 00 00 00 04, rdata=0x12345678 with ready after 5 cycles → wstrb=0, addr=0x04000000, tx 78 56 34 12 in order. Hold tx_ready low 3 cycles per byte; no byte is lost or repeated.
- Timeout: TIMEOUT_CYCLES=16, ready never asserted → valid high exactly 16 cycles, then deasserted, tx 0x54, busy low after accept. Repeat with ready in the 16th cycle → normal completion.
- Bad command: rx 0x41 → tx 0x3F, no bus_req. Then a valid read frame → normal response.
- Resync: RX_IDLE_CYCLES=100, rx 57 01 02 then 100 idle cycles → IDLE, no bus activity. Then a full read frame is decoded correctly.
- Reset mid-BUS with valid high → next edge valid=0, bus_req=0, tx_valid=0, busy=0. Later bytes are decoded from IDLE.
